// File: rtl/i2c_reg_target_pkg.sv
// Shared definitions for the I2C register-pointer target: FSM states and byte framing.
package i2c_reg_target_pkg;

  localparam int I2C_BYTE_W = 8;
  // R/W flag position inside the address byte (LSB on the wire).
  localparam int RW_BIT     = 0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8
  } state_e;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Register-bank side of the I2C target: pointer, write strobe/data, read strobe/data.
interface i2c_reg_target_if
  import i2c_reg_target_pkg::*;
#(
  parameter int PTR_W = 3
);

  logic [PTR_W-1:0]      reg_addr;
  logic [I2C_BYTE_W-1:0] reg_wdata;
  logic                  reg_wr_en;
  logic [I2C_BYTE_W-1:0] reg_rdata;
  logic                  reg_rd_en;

  // The I2C target owns the pointer and strobes; the register bank answers with read data.
  modport master (
    output reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one pad line plus single-cycle rise/fall detection.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a shift chain rather than a single wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with register pointer: auto-incrementing multi-byte writes, SDA-driven reads,
// repeated START and master NACK handling. No clock stretching.
module i2c_reg_target
  import i2c_reg_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h69,
  parameter int         NUM_REGS    = 8,
  parameter int         PTR_W       = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  output logic              scl_o,
  input  logic              sda_i,
  output logic              sda_o,
  i2c_reg_target_if.master  bus,
  output logic              start,
  output logic              stop,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .async_in(scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .async_in(sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // Bus conditions: SDA moving while SCL is high is never a data bit.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic                  sda_q, sda_d;

  logic [PTR_W-1:0]      reg_addr_q, ptr_next;
  logic [I2C_BYTE_W-1:0] reg_wdata_q;
  logic                  reg_wr_en_q, start_q, stop_q, busy_q;

  logic [I2C_BYTE_W-1:0] byte_in;
  logic                  rd_fire, wr_fire, ptr_load, ptr_step, busy_set, busy_clr;

  assign ptr_next = (reg_addr_q == PTR_W'(NUM_REGS - 1)) ? '0 : reg_addr_q + 1'b1;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    rw_d     = rw_q;
    sda_d    = sda_q;
    byte_in  = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    ptr_load = 1'b0;
    ptr_step = 1'b0;
    busy_set = 1'b0;
    busy_clr = 1'b0;

    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sda_d    = 1'b1;
      busy_clr = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(I2C_BYTE_W - 1)) begin
              cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (byte_in[I2C_BYTE_W-1:1] == ADDRESS) begin
                  state_d  = S_ADDR_ACK;
                  rw_d     = byte_in[RW_BIT];
                  busy_set = 1'b1;
                end else begin
                  state_d  = S_IDLE;
                  busy_clr = 1'b1;
                end
              end else if (state_q == S_PTR) begin
                ptr_load = 1'b1;
                state_d  = S_PTR_ACK;
              end else begin
                wr_fire = 1'b1;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end

        // cnt 0: waiting for the fall that opens the ACK slot; cnt 1: waiting for the one closing it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_d = 1'b0;
              cnt_d = 4'd1;
            end else begin
              sda_d = 1'b1;
              cnt_d = '0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                rd_fire = 1'b1;
                sda_d   = bus.reg_rdata[I2C_BYTE_W-1];
                shift_d = {bus.reg_rdata[I2C_BYTE_W-2:0], 1'b0};
                cnt_d   = 4'd1;
                state_d = S_RDATA;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        // cnt counts bits already placed on SDA; 0 means the next byte still has to be fetched.
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              rd_fire = 1'b1;
              sda_d   = bus.reg_rdata[I2C_BYTE_W-1];
              shift_d = {bus.reg_rdata[I2C_BYTE_W-2:0], 1'b0};
              cnt_d   = 4'd1;
            end else if (cnt_q == 4'(I2C_BYTE_W)) begin
              sda_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_RACK;
            end else begin
              sda_d   = shift_q[I2C_BYTE_W-1];
              shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end

        // Pointer advances on the ACK so the following fetch already sees the next register.
        S_RACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              ptr_step = 1'b1;
              cnt_d    = '0;
              state_d  = S_RDATA;
            end else begin
              busy_clr = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      rw_q    <= 1'b0;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      sda_q   <= sda_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_en_q <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_wr_en_q <= wr_fire;
      start_q     <= start_det;
      stop_q      <= stop_det;
      if (wr_fire) reg_wdata_q <= byte_in;
      // A written byte advances the pointer during its strobe cycle, after the bank saw the old value.
      if (ptr_load)                     reg_addr_q <= byte_in[PTR_W-1:0];
      else if (reg_wr_en_q || ptr_step) reg_addr_q <= ptr_next;
      if (busy_clr)      busy_q <= 1'b0;
      else if (busy_set) busy_q <= 1'b1;
    end
  end

  assign scl_o         = 1'b1;
  assign sda_o         = sda_q;
  assign start         = start_q;
  assign stop          = stop_q;
  assign busy          = busy_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr_en = reg_wr_en_q;
  // The read strobe marks the exact cycle reg_rdata is captured, so it is not registered.
  assign bus.reg_rd_en = rd_fire & ~reset;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench: a bit-banged I2C master, a 0x50+addr register bank and strobe scoreboards.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk, reset;
  logic scl_m, sda_m, sda_line;
  logic scl_o, sda_o, start, stop, busy;

  int tests_run = 0, tests_failed = 0;
  int start_cnt = 0, stop_cnt = 0, wr_cnt = 0, rd_cnt = 0, sda_low_cnt = 0;
  int ptr_model = 0;
  wr_t        wr_q[$];
  logic [2:0] rd_q[$];
  wr_t        wr_e;
  logic [2:0] rd_e;

  i2c_reg_target_if #(.PTR_W(3)) bus ();

  assign sda_line      = sda_m & sda_o;
  assign bus.reg_rdata = 8'h50 + {5'd0, bus.reg_addr};

  i2c_reg_target #(.ADDRESS(7'h69), .NUM_REGS(8), .PTR_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .scl_o(scl_o), .sda_i(sda_line), .sda_o(sda_o),
    .bus(bus), .start(start), .stop(stop), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: strobes are matched against queued expectations as they happen.
  always @(negedge clk) begin
    if (!reset) begin
      if (!sda_o) sda_low_cnt++;
      if (start)  start_cnt++;
      if (stop)   stop_cnt++;
      if (bus.reg_wr_en) begin
        wr_cnt++;
        check("wr_rd_exclusive", 32'(bus.reg_rd_en), 0);
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          wr_e = wr_q.pop_front();
          check("wr_addr", 32'(bus.reg_addr), 32'(wr_e.addr));
          check("wr_data", 32'(bus.reg_wdata), 32'(wr_e.data));
        end
      end
      if (bus.reg_rd_en) begin
        rd_cnt++;
        check("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          rd_e = rd_q.pop_front();
          check("rd_addr", 32'(bus.reg_addr), 32'(rd_e));
        end
      end
    end
  end

  task automatic quarter();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    sda_m = b;
    quarter();
    scl_m = 1'b1;
    quarter();
    seen = sda_line;
    quarter();
    scl_m = 1'b0;
    quarter();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    quarter();
    scl_m = 1'b1;
    quarter();
    sda_m = 1'b0;
    quarter();
    scl_m = 1'b0;
    quarter();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    quarter();
    scl_m = 1'b1;
    quarter();
    sda_m = 1'b1;
    quarter();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  task automatic expect_write(input logic [7:0] d);
    wr_q.push_back('{addr: 3'(ptr_model), data: d});
    ptr_model = (ptr_model + 1) % 8;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         s0, w0, r0;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda_o", 32'(sda_o), 1);
    check("rst_scl_o", 32'(scl_o), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_reg_addr", 32'(bus.reg_addr), 0);
    check("rst_strobes", 32'({bus.reg_wr_en, bus.reg_rd_en, start, stop}), 0);
    reset = 1'b0;
    quarter();

    // Pointer 2, two data bytes, STOP.
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hD2, ack); check("t1_addr_ack", 32'(ack), 1);
    check("t1_busy", 32'(busy), 1);
    write_byte(8'h02, ack); check("t1_ptr_ack", 32'(ack), 1);
    ptr_model = 2;
    expect_write(8'hAB);
    write_byte(8'hAB, ack); check("t1_d0_ack", 32'(ack), 1);
    expect_write(8'hCD);
    write_byte(8'hCD, ack); check("t1_d1_ack", 32'(ack), 1);
    i2c_stop();
    quarter();
    check("t1_ptr_final", 32'(bus.reg_addr), 4);
    check("t1_stop_pulse", stop_cnt - s0, 1);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_wr_count", 32'(wr_cnt), 2);

    // Pointer 5, repeated START, read two bytes (ACK then NACK).
    i2c_start();
    write_byte(8'hD2, ack); check("t2_addr_ack", 32'(ack), 1);
    write_byte(8'h05, ack); check("t2_ptr_ack", 32'(ack), 1);
    rd_q.push_back(3'd5);
    rd_q.push_back(3'd6);
    i2c_start();
    write_byte(8'hD3, ack); check("t2_raddr_ack", 32'(ack), 1);
    check("t2_busy", 32'(busy), 1);
    read_byte(1'b1, rb); check("t2_rdata0", 32'(rb), 32'h55);
    read_byte(1'b0, rb); check("t2_rdata1", 32'(rb), 32'h56);
    quarter();
    check("t2_busy_after_nack", 32'(busy), 0);
    i2c_stop();
    quarter();
    check("t2_ptr_final", 32'(bus.reg_addr), 6);
    check("t2_rd_count", 32'(rd_cnt), 2);

    // Foreign address 0x42 is ignored entirely.
    w0 = wr_cnt; r0 = rd_cnt; sda_low_cnt = 0;
    i2c_start();
    write_byte(8'h84, ack); check("t3_nack_addr", 32'(ack), 0);
    write_byte(8'h10, ack); check("t3_nack_data", 32'(ack), 0);
    check("t3_busy", 32'(busy), 0);
    i2c_stop();
    quarter();
    check("t3_sda_never_low", 32'(sda_low_cnt), 0);
    check("t3_no_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 0);

    // Next transaction to 0x69 works; three writes from pointer 7 wrap to 0, 1.
    i2c_start();
    write_byte(8'hD2, ack); check("t4_addr_ack", 32'(ack), 1);
    write_byte(8'h07, ack); check("t4_ptr_ack", 32'(ack), 1);
    ptr_model = 7;
    expect_write(8'h11); write_byte(8'h11, ack);
    expect_write(8'h22); write_byte(8'h22, ack);
    expect_write(8'h33); write_byte(8'h33, ack); check("t4_last_ack", 32'(ack), 1);
    i2c_stop();
    quarter();
    check("t4_ptr_final", 32'(bus.reg_addr), 2);

    // STOP after four data bits: partial byte discarded.
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hD2, ack);
    write_byte(8'h03, ack); check("t5_ptr_ack", 32'(ack), 1);
    ptr_model = 3;
    clock_bit(1'b1, ack); clock_bit(1'b0, ack); clock_bit(1'b1, ack); clock_bit(1'b0, ack);
    i2c_stop();
    quarter();
    check("t5_no_wr", 32'(wr_cnt - w0), 0);
    check("t5_sda_o", 32'(sda_o), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_ptr", 32'(bus.reg_addr), 3);

    // Reset while the target drives bit 7 (0) of 0x51 in a read.
    i2c_start();
    write_byte(8'hD2, ack);
    write_byte(8'h01, ack);
    rd_q.push_back(3'd1);
    i2c_start();
    write_byte(8'hD3, ack); check("t6_raddr_ack", 32'(ack), 1);
    check("t6_sda_driven_low", 32'(sda_o), 0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_sda_o", 32'(sda_o), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_reg_addr", 32'(bus.reg_addr), 0);
    check("t6_rst_reg_wdata", 32'(bus.reg_wdata), 0);
    check("t6_rst_strobes", 32'({bus.reg_wr_en, bus.reg_rd_en, start, stop}), 0);
    reset = 1'b0;
    sda_m = 1'b1;
    quarter();
    s0 = start_cnt;
    i2c_start();
    check("t6_start_after_rst", start_cnt - s0, 1);
    write_byte(8'hD2, ack); check("t6_addr_ack", 32'(ack), 1);
    write_byte(8'h04, ack);
    ptr_model = 4;
    expect_write(8'h77); write_byte(8'h77, ack); check("t6_data_ack", 32'(ack), 1);
    i2c_stop();
    quarter();
    check("t6_ptr_final", 32'(bus.reg_addr), 5);

    check("end_wr_queue_drained", 32'(wr_q.size()), 0);
    check("end_rd_queue_drained", 32'(rd_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
